// File: rtl/change_dispenser_pkg.sv
// rtl/change_dispenser_pkg.sv - shared coin table and FSM encodings for the change dispenser
package change_dispenser_pkg;

    localparam int kNumCoins = 3;

    localparam int kCoinV0 = 100;
    localparam int kCoinV1 = 500;
    localparam int kCoinV2 = 1000;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SELECT   = 2'd1;
    localparam logic [1:0] ST_DISPENSE = 2'd2;
    localparam logic [1:0] ST_FINISH   = 2'd3;

endpackage

// File: rtl/change_dispenser_coin_picker.sv
// rtl/change_dispenser_coin_picker.sv - picks the largest stocked coin not exceeding the balance
module change_dispenser_coin_picker
    import change_dispenser_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COIN_V0 = kCoinV0,
    parameter int COIN_V1 = kCoinV1,
    parameter int COIN_V2 = kCoinV2
) (
    input  logic [WIDTH-1:0]     balance,
    input  logic [kNumCoins-1:0] stock_empty,
    output logic                 found,
    output logic [kNumCoins-1:0] sel,
    output logic [WIDTH-1:0]     value
);

    localparam logic [WIDTH-1:0] V0 = WIDTH'(COIN_V0);
    localparam logic [WIDTH-1:0] V1 = WIDTH'(COIN_V1);
    localparam logic [WIDTH-1:0] V2 = WIDTH'(COIN_V2);

    logic [kNumCoins-1:0] usable;

    // A coin is usable only if it fits the balance, so the later subtraction cannot wrap.
    assign usable[0] = (V0 <= balance) && !stock_empty[0];
    assign usable[1] = (V1 <= balance) && !stock_empty[1];
    assign usable[2] = (V2 <= balance) && !stock_empty[2];

    always_comb begin
        found = 1'b0;
        sel   = '0;
        value = '0;
        if (usable[2]) begin
            found = 1'b1;
            sel   = 3'b100;
            value = V2;
        end else if (usable[1]) begin
            found = 1'b1;
            sel   = 3'b010;
            value = V1;
        end else if (usable[0]) begin
            found = 1'b1;
            sel   = 3'b001;
            value = V0;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out a refund balance one coin per hopper handshake
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COIN_V0 = kCoinV0,
    parameter int COIN_V1 = kCoinV1,
    parameter int COIN_V2 = kCoinV2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_amount,
    input  logic [kNumCoins-1:0] i_stock_empty,
    input  logic                 i_coin_ready,
    output logic                 o_coin_valid,
    output logic [kNumCoins-1:0] o_coin_sel,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [WIDTH-1:0]     o_remain,
    output logic                 o_error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]           state;
    logic [WIDTH-1:0]     balance;
    logic [WIDTH-1:0]     coin_value;
    logic [TW-1:0]        timer;

    logic                 pick_found;
    logic [kNumCoins-1:0] pick_sel;
    logic [WIDTH-1:0]     pick_value;

    change_dispenser_coin_picker #(
        .WIDTH  (WIDTH),
        .COIN_V0(COIN_V0),
        .COIN_V1(COIN_V1),
        .COIN_V2(COIN_V2)
    ) u_picker (
        .balance    (balance),
        .stock_empty(i_stock_empty),
        .found      (pick_found),
        .sel        (pick_sel),
        .value      (pick_value)
    );

    assign o_busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            balance      <= '0;
            coin_value   <= '0;
            timer        <= '0;
            o_coin_valid <= 1'b0;
            o_coin_sel   <= '0;
            o_done       <= 1'b0;
            o_remain     <= '0;
            o_error      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        balance  <= i_amount;
                        o_error  <= 1'b0;
                        o_remain <= '0;
                        state    <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (pick_found) begin
                        o_coin_sel   <= pick_sel;
                        o_coin_valid <= 1'b1;
                        coin_value   <= pick_value;
                        timer        <= '0;
                        state        <= ST_DISPENSE;
                    end else begin
                        o_done   <= 1'b1;
                        o_remain <= balance;
                        state    <= ST_FINISH;
                    end
                end
                ST_DISPENSE: begin
                    // The request is never retracted early; stock flags are ignored here.
                    if (i_coin_ready) begin
                        balance      <= balance - coin_value;
                        o_coin_valid <= 1'b0;
                        o_coin_sel   <= '0;
                        state        <= ST_SELECT;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        o_coin_valid <= 1'b0;
                        o_coin_sel   <= '0;
                        o_error      <= 1'b1;
                        o_done       <= 1'b1;
                        o_remain     <= balance;
                        state        <= ST_FINISH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for the change dispenser
module tb_change_dispenser;

    logic        clk;
    logic        reset_n;
    logic        i_start;
    logic [31:0] i_amount;
    logic [2:0]  i_stock_empty;
    logic        i_coin_ready;
    logic        o_coin_valid;
    logic [2:0]  o_coin_sel;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_remain;
    logic        o_error;

    int checks = 0;
    int errors = 0;

    logic [2:0]  exp_q[$];
    logic [2:0]  obs_q[$];
    int          done_seen;
    int          done_cyc;
    int          first_valid;
    int          valid_cycles;
    int          sel_bad;
    int          sel_unstable;
    logic [31:0] remain_seen;
    logic        err_seen;

    change_dispenser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (i_start),
        .i_amount     (i_amount),
        .i_stock_empty(i_stock_empty),
        .i_coin_ready (i_coin_ready),
        .o_coin_valid (o_coin_valid),
        .o_coin_sel   (o_coin_sel),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_remain     (o_remain),
        .o_error      (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_req(input logic [31:0] amt, input logic [2:0] empty);
        @(negedge clk);
        i_stock_empty = empty;
        i_amount      = amt;
        i_start       = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // delay 0: ready always high; delay > 0: ready after that many waiting cycles; < 0: never.
    task automatic run_hopper(input int delay, input bit pulse);
        int         wait_cnt;
        logic [2:0] cur;
        wait_cnt     = 0;
        cur          = '0;
        done_seen    = 0;
        done_cyc     = -1;
        first_valid  = -1;
        valid_cycles = 0;
        sel_bad      = 0;
        sel_unstable = 0;
        remain_seen  = '0;
        err_seen     = 1'b0;
        obs_q.delete();
        i_coin_ready = (delay == 0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (i_start) i_start = 1'b0;
            if (o_done) begin
                done_seen   = 1;
                done_cyc    = cyc;
                remain_seen = o_remain;
                err_seen    = o_error;
                break;
            end
            if (!o_coin_valid && o_coin_sel != 3'b000) sel_bad++;
            if (o_coin_valid) begin
                if (first_valid < 0) first_valid = cyc;
                valid_cycles++;
                if (wait_cnt == 0) cur = o_coin_sel;
                else if (o_coin_sel !== cur) sel_unstable++;
                wait_cnt++;
                if (pulse && wait_cnt == 2) begin
                    i_amount = 32'd9999;
                    i_start  = 1'b1;
                end
                if (delay > 0 && wait_cnt > delay) i_coin_ready = 1'b1;
                if (i_coin_ready) begin
                    obs_q.push_back(o_coin_sel);
                    wait_cnt = 0;
                end
            end else if (delay > 0) begin
                i_coin_ready = 1'b0;
            end
        end
        i_coin_ready = 1'b0;
        i_start      = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_busy, o_coin_valid, o_coin_sel, o_done, o_error} !== 7'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0", {o_busy, o_coin_valid, o_coin_sel, o_done, o_error});
        end
        checks++;
        if (o_remain !== 32'd0) begin
            errors++;
            $display("FAIL reset_remain: got %0d required 0", o_remain);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_greedy;
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
        start_req(32'd1600, 3'b000);
        run_hopper(0, 1'b0);
        checks++;
        if (done_seen !== 1) begin errors++; $display("FAIL greedy_done: got %0d required 1", done_seen); end
        checks++;
        if (first_valid !== 1) begin errors++; $display("FAIL greedy_latency: got %0d required 1", first_valid); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL greedy_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [2:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL greedy_coin: got %b required %b", o, e); end
        end
        exp_q.delete();
        checks++;
        if (remain_seen !== 32'd0) begin errors++; $display("FAIL greedy_remain: got %0d required 0", remain_seen); end
        checks++;
        if (sel_bad !== 0) begin errors++; $display("FAIL greedy_sel_idle: got %0d required 0", sel_bad); end
        @(negedge clk);
        checks++;
        if ({o_done, o_busy} !== 2'b00) begin errors++; $display("FAIL greedy_done_pulse: got %b required 00", {o_done, o_busy}); end
    endtask

    task automatic test_empty_skip;
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b010);
        start_req(32'd1000, 3'b100);
        run_hopper(0, 1'b0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL skip_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [2:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL skip_coin: got %b required %b", o, e); end
        end
        exp_q.delete();
        checks++;
        if (remain_seen !== 32'd0 || done_seen !== 1) begin errors++; $display("FAIL skip_remain: got %0d/%0d required 0/1", remain_seen, done_seen); end
    endtask

    task automatic test_unpayable;
        start_req(32'd250, 3'b001);
        run_hopper(0, 1'b0);
        checks++;
        if (done_cyc !== 1) begin errors++; $display("FAIL unpayable_done_cyc: got %0d required 1", done_cyc); end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL unpayable_count: got %0d required 0", obs_q.size()); end
        checks++;
        if (remain_seen !== 32'd250) begin errors++; $display("FAIL unpayable_remain: got %0d required 250", remain_seen); end
        @(negedge clk);
        checks++;
        if (o_remain !== 32'd250) begin errors++; $display("FAIL unpayable_hold: got %0d required 250", o_remain); end
    endtask

    task automatic test_remainder;
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b001);
        start_req(32'd1750, 3'b000);
        run_hopper(0, 1'b0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL remainder_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [2:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL remainder_coin: got %b required %b", o, e); end
        end
        exp_q.delete();
        checks++;
        if (remain_seen !== 32'd50) begin errors++; $display("FAIL remainder_remain: got %0d required 50", remain_seen); end
    endtask

    task automatic test_zero;
        start_req(32'd0, 3'b000);
        run_hopper(0, 1'b0);
        checks++;
        if (done_cyc !== 1 || obs_q.size() !== 0) begin errors++; $display("FAIL zero_done: got cyc %0d coins %0d required 1/0", done_cyc, obs_q.size()); end
        checks++;
        if (remain_seen !== 32'd0) begin errors++; $display("FAIL zero_remain: got %0d required 0", remain_seen); end
    endtask

    task automatic test_timeout;
        start_req(32'd500, 3'b000);
        run_hopper(-1, 1'b0);
        checks++;
        if (valid_cycles !== 64) begin errors++; $display("FAIL timeout_valid_cycles: got %0d required 64", valid_cycles); end
        checks++;
        if (err_seen !== 1'b1 || done_seen !== 1) begin errors++; $display("FAIL timeout_error: got %b/%0d required 1/1", err_seen, done_seen); end
        checks++;
        if (remain_seen !== 32'd500) begin errors++; $display("FAIL timeout_remain: got %0d required 500", remain_seen); end
    endtask

    task automatic test_back_to_back_delay;
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
        start_req(32'd600, 3'b000);
        checks++;
        if (o_error !== 1'b0 || o_remain !== 32'd0) begin errors++; $display("FAIL delay_clear: got %b/%0d required 0/0", o_error, o_remain); end
        run_hopper(5, 1'b1);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL delay_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [2:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL delay_coin: got %b required %b", o, e); end
        end
        exp_q.delete();
        checks++;
        if (sel_unstable !== 0) begin errors++; $display("FAIL delay_sel_stable: got %0d required 0", sel_unstable); end
        checks++;
        if (valid_cycles !== 12) begin errors++; $display("FAIL delay_valid_cycles: got %0d required 12", valid_cycles); end
        checks++;
        if (remain_seen !== 32'd0) begin errors++; $display("FAIL delay_remain: got %0d required 0", remain_seen); end
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL delay_start_ignored: got busy %b required 0", o_busy); end
    endtask

    task automatic test_reset_mid;
        int dones;
        dones = 0;
        start_req(32'd500, 3'b000);
        i_coin_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_coin_valid !== 1'b1) begin errors++; $display("FAIL midreset_pending: got %b required 1", o_coin_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_coin_valid, o_coin_sel, o_done} !== 6'd0) begin errors++; $display("FAIL midreset_async: got %b required 0", {o_busy, o_coin_valid, o_coin_sel, o_done}); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d required 0", dones); end
        exp_q.push_back(3'b001);
        start_req(32'd100, 3'b000);
        run_hopper(0, 1'b0);
        checks++;
        if (obs_q.size() !== 1 || done_seen !== 1) begin errors++; $display("FAIL midreset_restart: got coins %0d done %0d required 1/1", obs_q.size(), done_seen); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [2:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL midreset_coin: got %b required %b", o, e); end
        end
        exp_q.delete();
    endtask

    initial begin
        reset_n       = 1'b0;
        i_start       = 1'b0;
        i_amount      = '0;
        i_stock_empty = '0;
        i_coin_ready  = 1'b0;
        test_reset();
        test_greedy();
        test_empty_skip();
        test_unpayable();
        test_remainder();
        test_zero();
        test_timeout();
        test_back_to_back_delay();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
